sync_fifo_mc: RTL

Single-clock, multi-channel FIFO: NUM_CH independent queues of DEPTH entries each share one storage array, one write port and one read port, selected per cycle by channel index. It is the parametrised successor to the team's dual-clock FIFO for paths that need no clock crossing. Typical use is staging per-source traffic (per-channel request queues) ahead of an arbiter. It adds per-channel occupancy, almost-full and optional sticky error reporting.

---
 rtl/sync_fifo_mc_pkg.sv | 17 +
 rtl/sync_fifo_mc_if.sv | 37 +++
 rtl/sync_fifo_mc_ctrl.sv | 71 +++++++
 rtl/sync_fifo_mc.sv | 85 ++++++++
 4 files changed

// File: rtl/sync_fifo_mc_pkg.sv
// rtl/sync_fifo_mc_pkg.sv - shared constants and helpers for the multi-channel FIFO
package sync_fifo_mc_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_NUM_CH     = 4;

    // Channel index width; a single-channel FIFO still carries a 1-bit index.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int level_lsb(input int ch, input int aw);
        return ch * (aw + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mc_if.sv
// rtl/sync_fifo_mc_if.sv - write/read/status bundle of the multi-channel FIFO
interface sync_fifo_mc_if
    import sync_fifo_mc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int NUM_CH     = DEF_NUM_CH
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = ch_width(NUM_CH);

    logic                       wr_en;
    logic [CW-1:0]              wr_ch;
    logic [DATA_WIDTH-1:0]      wr_data;
    logic                       rd_en;
    logic [CW-1:0]              rd_ch;
    logic [DATA_WIDTH-1:0]      rd_data;
    logic                       rd_valid;
    logic [NUM_CH-1:0]          full;
    logic [NUM_CH-1:0]          empty;
    logic [NUM_CH-1:0]          almost_full;
    logic [NUM_CH*(AW+1)-1:0]   level;
    logic                       err_clr;
    logic [NUM_CH-1:0]          wr_ovf;
    logic [NUM_CH-1:0]          rd_udf;

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, rd_ch, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, level, wr_ovf, rd_udf
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, rd_ch, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, level, wr_ovf, rd_udf
    );

endinterface

// File: rtl/sync_fifo_mc_ctrl.sv
// rtl/sync_fifo_mc_ctrl.sv - one channel's pointer pair, status flags and sticky errors
// Sticky wr_ovf/rd_udf exist only when SYNC_FIFO_MC_ERR_EN is defined.
module sync_fifo_mc_ctrl
    import sync_fifo_mc_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req,
    input  logic          rd_req,
    input  logic          err_clr,
    output logic          wr_acc,
    output logic          rd_acc,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [AW:0]   level,
    output logic          wr_ovf,
    output logic          rd_udf
);
    localparam logic [AW:0] AF_LEVEL = (AW+1)'(AF_THRESH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Flags come from start-of-cycle pointers only, so a same-cycle read never unblocks a write.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level       = wr_ptr - rd_ptr;
    assign almost_full = (level >= AF_LEVEL);
    assign wr_acc      = wr_req && !full;
    assign rd_acc      = rd_req && !empty;
    assign wr_addr     = wr_ptr[AW-1:0];
    assign rd_addr     = rd_ptr[AW-1:0];

`ifdef SYNC_FIFO_MC_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ovf <= 1'b0;
            rd_udf <= 1'b0;
        end else if (err_clr) begin
            wr_ovf <= 1'b0;
            rd_udf <= 1'b0;
        end else begin
            if (wr_req && full)  wr_ovf <= 1'b1;
            if (rd_req && empty) rd_udf <= 1'b1;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign wr_ovf = 1'b0;
    assign rd_udf = 1'b0;
`endif

endmodule

// File: rtl/sync_fifo_mc.sv
// rtl/sync_fifo_mc.sv - single-clock multi-channel FIFO: shared storage, channel decode, read register
module sync_fifo_mc
    import sync_fifo_mc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int AF_THRESH  = FIFO_DEPTH - 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_fifo_mc_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = ch_width(NUM_CH);

    logic [DATA_WIDTH-1:0] mem [NUM_CH*FIFO_DEPTH];

    logic [NUM_CH-1:0] wr_acc, rd_acc;
    logic [NUM_CH-1:0] full_v, empty_v, af_v, ovf_v, udf_v;
    logic [AW-1:0]     wr_addr_a [NUM_CH];
    logic [AW-1:0]     rd_addr_a [NUM_CH];
    logic [AW:0]       level_a   [NUM_CH];
    logic [CW+AW-1:0]  wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic              rd_valid_q;

    // Out-of-range channel indices match no controller, so such requests vanish without side effects.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sync_fifo_mc_ctrl #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .AF_THRESH  (AF_THRESH)
        ) u_ctrl (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_req      (bus.wr_en && (bus.wr_ch == CW'(c))),
            .rd_req      (bus.rd_en && (bus.rd_ch == CW'(c))),
            .err_clr     (bus.err_clr),
            .wr_acc      (wr_acc[c]),
            .rd_acc      (rd_acc[c]),
            .wr_addr     (wr_addr_a[c]),
            .rd_addr     (rd_addr_a[c]),
            .full        (full_v[c]),
            .empty       (empty_v[c]),
            .almost_full (af_v[c]),
            .level       (level_a[c]),
            .wr_ovf      (ovf_v[c]),
            .rd_udf      (udf_v[c])
        );
    end

    always_comb begin
        wr_addr   = '0;
        rd_addr   = '0;
        bus.level = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_acc[c]) wr_addr = {CW'(c), wr_addr_a[c]};
            if (rd_acc[c]) rd_addr = {CW'(c), rd_addr_a[c]};
            bus.level[level_lsb(c, AW) +: AW+1] = level_a[c];
        end
    end

    always_ff @(posedge clk) begin
        if (|wr_acc) mem[wr_addr] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= |rd_acc;
            if (|rd_acc) rd_data_q <= mem[rd_addr];
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.full        = full_v;
    assign bus.empty       = empty_v;
    assign bus.almost_full = af_v;
    assign bus.wr_ovf      = ovf_v;
    assign bus.rd_udf      = udf_v;

endmodule
